// File: rtl/sd_bus_pkg.sv
// Shared types and helpers for the SD bus channel model.
// Line vector layout: bit 0 CMD, bit 1+i DAT[i].
package sd_bus_pkg;

  typedef enum logic [1:0] {
    BW1 = 2'd0,
    BW4 = 2'd1,
    BW8 = 2'd2
  } bus_width_e;

  typedef struct packed {
    logic en;
    logic val;
  } line_drive_t;

  localparam int MaxLines = 9;

  function automatic logic [MaxLines-1:0] active_mask(
    bus_width_e bw,
    int         dat_width
  );
    int n;
    case (bw)
      BW8:     n = 8;
      BW4:     n = 4;
      default: n = 1;
    endcase
    if (n > dat_width) n = dat_width;
    active_mask    = '0;
    active_mask[0] = 1'b1;
    for (int i = 0; i < MaxLines - 1; i++)
      active_mask[i+1] = (i < n);
  endfunction

endpackage

// File: rtl/sd_bus_delay.sv
// Circular delay line with a runtime tap.
// Tap must lie in 1..MaxDelay; tap == MaxDelay reads the oldest entry.
module sd_bus_delay #(
  parameter int               Width    = 1,
  parameter int               MaxDelay = 8,
  parameter logic [Width-1:0] RstVal   = '0,
  parameter int               DlyWidth = $clog2(MaxDelay + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DlyWidth-1:0] tap_i,
  input  logic [Width-1:0]    d_i,
  output logic [Width-1:0]    q_o
);

  localparam int PtrW = (MaxDelay > 1) ? $clog2(MaxDelay) : 1;
  localparam int IdxW = ((PtrW > DlyWidth) ? PtrW : DlyWidth) + 1;

  logic [Width-1:0] mem [MaxDelay];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic [IdxW-1:0]  wp_x;
  logic [IdxW-1:0]  tap_x;
  logic [IdxW-1:0]  idx;
  logic             unused_idx;

  always_comb begin
    wp_x  = IdxW'(wptr);
    tap_x = IdxW'(tap_i);
    if (wp_x >= tap_x) idx = wp_x - tap_x;
    else               idx = wp_x + IdxW'(MaxDelay) - tap_x;
    rptr = idx[PtrW-1:0];
  end

  assign unused_idx = ^idx[IdxW-1:PtrW];
  assign q_o        = mem[rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      for (int i = 0; i < MaxDelay; i++)
        mem[i] <= RstVal;
    end else begin
      mem[wptr] <= d_i;
      if (wptr == PtrW'(MaxDelay - 1)) wptr <= '0;
      else                             wptr <= wptr + 1'b1;
    end
  end

endmodule

// File: rtl/sd_bus_channel.sv
// SD CMD/DAT bus model: delayed host drive, immediate card drive,
// pull-up resolution and sticky contention statistics.
module sd_bus_channel
  import sd_bus_pkg::*;
#(
  parameter int DatWidth = 4,
  parameter int MaxDelay = 8,
  parameter int CntWidth = 16,
  parameter int DlyWidth = $clog2(MaxDelay + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DlyWidth-1:0] host_dly_i,
  input  logic [1:0]          bus_width_i,
  input  logic                clear_i,
  input  logic                host_cmd_en_i,
  input  logic                host_cmd_i,
  output logic                host_cmd_o,
  input  logic [DatWidth-1:0] host_dat_en_i,
  input  logic [DatWidth-1:0] host_dat_i,
  output logic [DatWidth-1:0] host_dat_o,
  input  logic                card_cmd_en_i,
  input  logic                card_cmd_i,
  output logic                card_cmd_o,
  input  logic [DatWidth-1:0] card_dat_en_i,
  input  logic [DatWidth-1:0] card_dat_i,
  output logic [DatWidth-1:0] card_dat_o,
  output logic                contention_o,
  output logic [DatWidth:0]   contention_lines_o,
  output logic [CntWidth-1:0] contention_cnt_o
);

  localparam int N = 1 + DatWidth;

  logic [DlyWidth-1:0] dly;
  logic [N-1:0]        h_en;
  logic [N-1:0]        h_val;
  logic [N-1:0]        h_en_d;
  logic [N-1:0]        h_val_d;
  logic [N-1:0]        c_en;
  logic [N-1:0]        c_val;
  logic [N-1:0]        mask;
  logic [N-1:0]        bus;
  logic [N-1:0]        ret;
  logic [N-1:0]        contend;
  logic [MaxLines-1:0] mask_full;
  logic                unused_mask;

  always_comb begin
    if (host_dly_i == '0)
      dly = DlyWidth'(1);
    else if (host_dly_i > DlyWidth'(MaxDelay))
      dly = DlyWidth'(MaxDelay);
    else
      dly = host_dly_i;
  end

  assign h_en  = {host_dat_en_i, host_cmd_en_i};
  assign h_val = {host_dat_i, host_cmd_i};
  assign c_en  = {card_dat_en_i, card_cmd_en_i};
  assign c_val = {card_dat_i, card_cmd_i};

  assign mask_full   = active_mask(bus_width_e'(bus_width_i), DatWidth);
  assign mask        = mask_full[N-1:0];
  assign unused_mask = ^mask_full;

  sd_bus_delay #(
    .Width   (2 * N),
    .MaxDelay(MaxDelay),
    .RstVal  ('0),
    .DlyWidth(DlyWidth)
  ) u_host_dly (
    .clk_i,
    .rst_i,
    .tap_i(dly),
    .d_i  ({h_en, h_val}),
    .q_o  ({h_en_d, h_val_d})
  );

  // Wired-AND with pull-up: a released driver contributes a 1.
  always_comb begin
    line_drive_t h;
    line_drive_t c;
    h       = '0;
    c       = '0;
    bus     = '1;
    contend = '0;
    for (int i = 0; i < N; i++) begin
      h.en       = h_en_d[i] & mask[i];
      h.val      = h_val_d[i];
      c.en       = c_en[i] & mask[i];
      c.val      = c_val[i];
      bus[i]     = (~h.en | h.val) & (~c.en | c.val);
      contend[i] = h.en & c.en & (h.val ^ c.val);
    end
  end

  assign card_cmd_o = bus[0];
  assign card_dat_o = bus[N-1:1];

  sd_bus_delay #(
    .Width   (N),
    .MaxDelay(MaxDelay),
    .RstVal  ('1),
    .DlyWidth(DlyWidth)
  ) u_ret_dly (
    .clk_i,
    .rst_i,
    .tap_i(dly),
    .d_i  (bus),
    .q_o  (ret)
  );

  assign host_cmd_o = ret[0];
  assign host_dat_o = ret[N-1:1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      contention_o       <= 1'b0;
      contention_lines_o <= '0;
      contention_cnt_o   <= '0;
    end else if (clear_i) begin
      contention_o       <= 1'b0;
      contention_lines_o <= '0;
      contention_cnt_o   <= '0;
    end else if (|contend) begin
      contention_o       <= 1'b1;
      contention_lines_o <= contention_lines_o | contend;
      if (~&contention_cnt_o)
        contention_cnt_o <= contention_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_bus_channel.sv
// Scoreboard bench for sd_bus_channel: stimulus queues cycle-tagged
// expectations, a negedge monitor compares them when their cycle comes.
module tb_sd_bus_channel;

  localparam int DW   = 4;
  localparam int MD   = 8;
  localparam int DLYW = $clog2(MD + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [DLYW-1:0] dly;
  logic [1:0]      bw;
  logic            clr;
  logic            hce, hc, cce, cc;
  logic [DW-1:0]   hde, hd, cde, cd;

  logic            host_cmd_o, card_cmd_o, cont_o;
  logic [DW-1:0]   host_dat_o, card_dat_o;
  logic [DW:0]     lines_o;
  logic [15:0]     cnt_o;

  logic            s_host_cmd_o, s_card_cmd_o, s_cont_o;
  logic [DW-1:0]   s_host_dat_o, s_card_dat_o;
  logic [DW:0]     s_lines_o;
  logic [1:0]      s_cnt_o;

  always #5 clk = ~clk;

  sd_bus_channel #(.DatWidth(DW), .MaxDelay(MD), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .host_dly_i(dly), .bus_width_i(bw),
    .clear_i(clr),
    .host_cmd_en_i(hce), .host_cmd_i(hc), .host_cmd_o(host_cmd_o),
    .host_dat_en_i(hde), .host_dat_i(hd), .host_dat_o(host_dat_o),
    .card_cmd_en_i(cce), .card_cmd_i(cc), .card_cmd_o(card_cmd_o),
    .card_dat_en_i(cde), .card_dat_i(cd), .card_dat_o(card_dat_o),
    .contention_o(cont_o), .contention_lines_o(lines_o),
    .contention_cnt_o(cnt_o)
  );

  sd_bus_channel #(.DatWidth(DW), .MaxDelay(MD), .CntWidth(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .host_dly_i(dly), .bus_width_i(bw),
    .clear_i(clr),
    .host_cmd_en_i(hce), .host_cmd_i(hc), .host_cmd_o(s_host_cmd_o),
    .host_dat_en_i(hde), .host_dat_i(hd), .host_dat_o(s_host_dat_o),
    .card_cmd_en_i(cce), .card_cmd_i(cc), .card_cmd_o(s_card_cmd_o),
    .card_dat_en_i(cde), .card_dat_i(cd), .card_dat_o(s_card_dat_o),
    .contention_o(s_cont_o), .contention_lines_o(s_lines_o),
    .contention_cnt_o(s_cnt_o)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0:       return 32'(card_cmd_o);
      1:       return 32'(host_cmd_o);
      2:       return 32'(card_dat_o);
      3:       return 32'(host_dat_o);
      4:       return 32'(cont_o);
      5:       return 32'(lines_o);
      6:       return 32'(cnt_o);
      7:       return 32'(s_cnt_o);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_at(int c, int sel, logic [31:0] v, string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [31:0] a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        a = probe(sb[i].sel);
        n_chk++;
        if (sb[i].cyc == cyc && a == sb[i].val)
          n_pass++;
        else
          $display("FAIL %s cyc=%0d due=%0d got=%0h exp=%0h",
                   sb[i].name, cyc, sb[i].cyc, a, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t, c, s, r;
    rst = 1'b1; dly = DLYW'(3); bw = 2'd1; clr = 1'b0;
    hce = 0; hc = 1; cce = 0; cc = 1;
    hde = '0; hd = '1; cde = '0; cd = '1;
    tick(2);
    rst = 1'b0;
    t = cyc;
    expect_at(t, 0, 1, "rst_card_cmd");
    expect_at(t, 1, 1, "rst_host_cmd");
    expect_at(t, 2, 4'hF, "rst_card_dat");
    expect_at(t, 3, 4'hF, "rst_host_dat");
    expect_at(t, 4, 0, "rst_cont");
    expect_at(t, 5, 0, "rst_lines");
    expect_at(t, 6, 0, "rst_cnt");
    tick(2);

    // CMD pulse through D=3 each way
    hce = 1; hc = 0; t = cyc;
    expect_at(t + 2, 0, 1, "cmd_card_pre");
    expect_at(t + 3, 0, 0, "cmd_card");
    expect_at(t + 4, 0, 1, "cmd_card_end");
    expect_at(t + 5, 1, 1, "cmd_host_pre");
    expect_at(t + 6, 1, 0, "cmd_host_rt");
    expect_at(t + 7, 1, 1, "cmd_host_end");
    tick(); hce = 0; tick(10);

    // width masking
    bw = 2'd0; hde = 4'b1110; hd = '0; cde = 4'b1110; cd = '0; t = cyc;
    expect_at(t, 2, 4'hF, "bw1_card_now");
    expect_at(t + 3, 2, 4'hF, "bw1_card");
    expect_at(t + 6, 3, 4'hF, "bw1_host");
    expect_at(t + 6, 4, 0, "bw1_nocont");
    tick(7);
    bw = 2'd1; t = cyc;
    expect_at(t, 2, 4'b0001, "bw4_card");
    expect_at(t + 3, 3, 4'b0001, "bw4_host");
    expect_at(t + 3, 4, 0, "bw4_nocont");
    tick(4);
    bw = 2'd3; t = cyc;
    expect_at(t, 2, 4'hF, "bwrsv_card");
    tick(); hde = '0; cde = '0; bw = 2'd1; tick(10);

    // CMD contention, 5 cycles
    cce = 1; cc = 1; hce = 1; hc = 0; t = cyc;
    expect_at(t + 2, 0, 1, "cont_bus_pre");
    expect_at(t + 3, 0, 0, "cont_bus");
    expect_at(t + 3, 6, 0, "cont_cnt_pre");
    expect_at(t + 4, 4, 1, "cont_flag");
    expect_at(t + 8, 0, 1, "cont_bus_end");
    expect_at(t + 8, 6, 5, "cont_cnt5");
    expect_at(t + 8, 5, 5'b00001, "cont_lines_cmd");
    expect_at(t + 8, 7, 3, "small_sat5");
    tick(5); hce = 0; tick(5); cce = 0;

    // DAT[2] contention, 5 more cycles
    hde = 4'b0100; hd = '0; cde = 4'b0100; cd = 4'b0100; t = cyc;
    expect_at(t + 3, 2, 4'b1011, "dat2_bus");
    expect_at(t + 8, 6, 10, "cont_cnt10");
    expect_at(t + 8, 5, 5'b01001, "cont_lines_dat2");
    expect_at(t + 8, 7, 3, "small_sat10");
    tick(5); hde = '0; tick(5); cde = '0; tick(6);

    // clear coincident with a single contention cycle
    cce = 1; cc = 1; hce = 1; hc = 0; s = cyc;
    tick(); hce = 0; tick(2);
    c = cyc;
    clr = 1;
    expect_at(c, 0, 0, "clr_bus_contends");
    expect_at(c + 1, 4, 0, "clr_flag");
    expect_at(c + 1, 5, 0, "clr_lines");
    expect_at(c + 1, 6, 0, "clr_cnt");
    expect_at(c + 1, 7, 0, "clr_small_cnt");
    expect_at(c + 2, 6, 0, "clr_event_lost");
    tick(); clr = 0; tick(3); cce = 0; tick(10);

    // delay 0 behaves as 1
    dly = '0; hce = 1; hc = 0; t = cyc;
    expect_at(t + 1, 0, 0, "d0_card");
    expect_at(t + 2, 0, 1, "d0_card_end");
    expect_at(t + 2, 1, 0, "d0_host");
    expect_at(t + 3, 1, 1, "d0_host_end");
    tick(); hce = 0; tick(6);

    // delay above max clamps to MaxDelay
    dly = DLYW'(MD + 5); hce = 1; hc = 0; t = cyc;
    expect_at(t + 7, 0, 1, "dmax_card_pre");
    expect_at(t + 8, 0, 0, "dmax_card");
    expect_at(t + 9, 0, 1, "dmax_card_end");
    expect_at(t + 15, 1, 1, "dmax_host_pre");
    expect_at(t + 16, 1, 0, "dmax_host");
    tick(); hce = 0; tick(20);

    // long pattern run across many pointer wraps
    dly = DLYW'(5); hce = 1; hde = 4'hF; t = cyc;
    for (int i = 0; i < 30; i++) begin
      hd = 4'(i * 3 + 1);
      hc = i[1];
      expect_at(t + i + 5, 2, hd, "walk_card_dat");
      expect_at(t + i + 5, 0, hc, "walk_card_cmd");
      expect_at(t + i + 10, 3, hd, "walk_host_dat");
      tick();
    end
    hce = 0; hde = '0; tick(15);

    // reset mid-transfer flushes in-flight drive
    dly = DLYW'(3); hce = 1; hc = 0;
    tick(2);
    rst = 1; hce = 0;
    tick();
    rst = 0; r = cyc;
    for (int k = 0; k < 6; k++) expect_at(r + k, 0, 1, "rst_flush_card");
    for (int k = 0; k < 9; k++) expect_at(r + k, 1, 1, "rst_flush_host");
    expect_at(r, 6, 0, "rst_flush_cnt");

    for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
